// File: rtl/ahb_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_timer : zero-wait-state AHB-Lite down-counting timer with prescaler, IRQ
// Revision  : 1.0
// ----------------------------------------------------------------------------
module ahb_timer #(
  parameter int          PRESC_W    = 8,
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam logic [1:0] c_addr_ctrl   = 2'd0;
  localparam logic [1:0] c_addr_load   = 2'd1;
  localparam logic [1:0] c_addr_value  = 2'd2;
  localparam logic [1:0] c_addr_status = 2'd3;

  logic               dp_valid_q, dp_valid_d;
  logic               dp_write_q, dp_write_d;
  logic [1:0]         dp_addr_q,  dp_addr_d;
  logic               en_q,       en_d;
  logic               irq_en_q,   irq_en_d;
  logic               oneshot_q,  oneshot_d;
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic [PRESC_W-1:0] pcnt_q,     pcnt_d;
  logic [31:0]        load_q,     load_d;
  logic [31:0]        value_q,    value_d;
  logic               flag_q,     flag_d;

  logic        w_accept;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_flag_set;
  logic [31:0] w_ctrl_rd;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0]};

  assign w_accept    = HSEL & HREADY & HTRANS[1];
  assign w_wr        = dp_valid_q & dp_write_q & HREADY;
  assign w_wr_ctrl   = w_wr & (dp_addr_q == c_addr_ctrl);
  assign w_wr_load   = w_wr & (dp_addr_q == c_addr_load);
  assign w_wr_status = w_wr & (dp_addr_q == c_addr_status);
  assign w_tick      = en_q & (pcnt_q == presc_q);
  // A LOAD write in the tick cycle restarts the count, so the expiry is dropped.
  assign w_flag_set  = w_tick & ~w_wr_load & (value_q == 32'd0);

  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    if (HREADY) begin
      dp_valid_d = w_accept;
      dp_write_d = HWRITE;
      dp_addr_d  = HADDR[3:2];
    end
  end

  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = oneshot_q;
    presc_d   = presc_q;
    load_d    = load_q;
    value_d   = value_q;
    flag_d    = flag_q;
    pcnt_d    = '0;

    if (en_q && !w_tick) begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    if (w_tick && !w_wr_load) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else if (oneshot_q) begin
        en_d = 1'b0;
      end else begin
        value_d = load_q;
      end
    end

    if (w_wr_status && HWDATA[0]) begin
      flag_d = 1'b0;
    end
    if (w_flag_set) begin
      flag_d = 1'b1;
    end

    if (w_wr_ctrl) begin
      en_d      = HWDATA[0];
      irq_en_d  = HWDATA[1];
      oneshot_d = HWDATA[2];
      presc_d   = HWDATA[8 +: PRESC_W];
    end

    if (w_wr_load) begin
      load_d  = HWDATA;
      value_d = HWDATA;
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= 2'd0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      oneshot_q  <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      load_q     <= RESET_LOAD;
      value_q    <= RESET_LOAD;
      flag_q     <= 1'b0;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      oneshot_q  <= oneshot_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      load_q     <= load_d;
      value_q    <= value_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    w_ctrl_rd                = '0;
    w_ctrl_rd[0]             = en_q;
    w_ctrl_rd[1]             = irq_en_q;
    w_ctrl_rd[2]             = oneshot_q;
    w_ctrl_rd[8 +: PRESC_W]  = presc_q;
  end

  // Read data reflects live register contents, so a write in the previous
  // data phase is already visible here.
  always_comb begin
    HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        c_addr_ctrl:   HRDATA = w_ctrl_rd;
        c_addr_load:   HRDATA = load_q;
        c_addr_value:  HRDATA = value_q;
        default:       HRDATA = {31'd0, flag_q};
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = flag_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ahb_timer : directed bench for ahb_timer with a cycle-level register model
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_ahb_timer;

  localparam int          PRESC_W    = 8;
  localparam logic [31:0] RESET_LOAD = 32'h0000_0005;
  localparam logic [1:0]  c_idle     = 2'b00;
  localparam logic [1:0]  c_nonseq   = 2'b10;
  localparam logic [1:0]  c_ctrl     = 2'd0;
  localparam logic [1:0]  c_load     = 2'd1;
  localparam logic [1:0]  c_value    = 2'd2;
  localparam logic [1:0]  c_status   = 2'd3;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL    = 1'b0;
  logic [31:0] HADDR   = '0;
  logic [1:0]  HTRANS  = c_idle;
  logic        HWRITE  = 1'b0;
  logic [2:0]  HSIZE   = 3'd2;
  logic [31:0] HWDATA  = '0;
  logic        HREADY  = 1'b1;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        IRQ;

  ahb_timer #(
    .PRESC_W    (PRESC_W),
    .RESET_LOAD (RESET_LOAD)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Register-level model: timer rules applied once per clock to the old state.
  logic        m_en = 0, m_ie = 0, m_os = 0, m_flag = 0;
  logic        m_dv = 0, m_dw = 0;
  logic [1:0]  m_da = 0;
  logic [7:0]  m_presc = 0;
  logic [31:0] m_load = 0, m_value = 0;
  int          m_pcnt = 0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_en = 0; m_ie = 0; m_os = 0; m_flag = 0; m_presc = 0;
      m_load = RESET_LOAD; m_value = RESET_LOAD; m_pcnt = 0;
      m_dv = 0; m_dw = 0; m_da = 0;
    end else begin : model_cycle
      logic        wr_ctrl, wr_load, wr_stat, tick, nxt_en, nxt_flag;
      logic [31:0] nxt_value;
      int          nxt_pcnt;
      wr_ctrl  = m_dv && m_dw && HREADY && (m_da == c_ctrl);
      wr_load  = m_dv && m_dw && HREADY && (m_da == c_load);
      wr_stat  = m_dv && m_dw && HREADY && (m_da == c_status);
      tick     = m_en && (m_pcnt == int'(m_presc));
      nxt_pcnt = (m_en && !tick) ? m_pcnt + 1 : 0;
      nxt_value = m_value; nxt_en = m_en; nxt_flag = m_flag;
      if (wr_stat && HWDATA[0]) nxt_flag = 1'b0;
      if (tick && !wr_load) begin
        if (m_value == 32'd0) begin
          nxt_flag = 1'b1;
          if (m_os) nxt_en = 1'b0;
          else      nxt_value = m_load;
        end else begin
          nxt_value = m_value - 32'd1;
        end
      end
      if (wr_ctrl) begin
        nxt_en = HWDATA[0]; m_ie = HWDATA[1]; m_os = HWDATA[2]; m_presc = HWDATA[15:8];
      end
      if (wr_load) begin
        m_load = HWDATA; nxt_value = HWDATA; nxt_pcnt = 0;
      end
      m_en = nxt_en; m_flag = nxt_flag; m_value = nxt_value; m_pcnt = nxt_pcnt;
      if (HREADY) begin
        m_dv = HSEL && HTRANS[1]; m_dw = HWRITE; m_da = HADDR[3:2];
      end
    end
  end

  function automatic logic [31:0] model_rdata();
    if (!(m_dv && !m_dw)) return 32'd0;
    case (m_da)
      c_ctrl:  return {16'd0, m_presc, 5'd0, m_os, m_ie, m_en};
      c_load:  return m_load;
      c_value: return m_value;
      default: return {31'd0, m_flag};
    endcase
  endfunction

  always @(negedge HCLK) begin
    if (cmp_on) begin
      check("model_hrdata", HRDATA, model_rdata());
      check("model_irq", {31'd0, IRQ}, {31'd0, m_flag & m_ie});
      check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("hresp", {31'd0, HRESP}, 32'd0);
    end
  end

  logic [31:0] pend_wdata = '0;

  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [1:0] idx, input logic [31:0] wd, input logic rdy);
    HWDATA = pend_wdata;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HADDR  = {28'($urandom), idx, 2'($urandom)};
    HSIZE  = 3'($urandom);
    HREADY = rdy;
    if (sel && rdy && trans[1] && wr) pend_wdata = wd;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] data);
    step(1'b1, c_nonseq, 1'b1, idx, data, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, c_idle, 1'b0, 2'd0, 32'd0, 1'b1);
  endtask

  task automatic rd_check(input logic [1:0] idx, input logic [31:0] exp, input string name);
    step(1'b1, c_nonseq, 1'b0, idx, 32'd0, 1'b1);
    @(negedge HCLK);
    check(name, HRDATA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] seq_periodic [6];
    logic [31:0] seq_oneshot  [8];
    seq_periodic = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
    seq_oneshot  = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    @(posedge HCLK);
    cmp_on = 1'b1;
    @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    rd_check(c_load,   RESET_LOAD, "rst_load");
    rd_check(c_value,  RESET_LOAD, "rst_value");
    rd_check(c_ctrl,   32'd0,      "rst_ctrl");
    rd_check(c_status, 32'd0,      "rst_status");

    // Periodic, PRESC=0: VALUE steps every cycle and reloads after zero.
    wr_reg(c_load, 32'd3);
    wr_reg(c_ctrl, 32'h0000_0001);
    for (int i = 0; i < 6; i++) rd_check(c_value, seq_periodic[i], $sformatf("periodic_value_%0d", i));
    rd_check(c_status, 32'd1, "periodic_flag");
    check("periodic_irq_masked", {31'd0, IRQ}, 32'd0);

    // Write then immediate read, and non-transfers.
    wr_reg(c_ctrl, 32'h0000_0003);
    rd_check(c_ctrl, 32'h0000_0003, "ctrl_wr_rd");
    check("irq_enabled", {31'd0, IRQ}, 32'd1);
    step(1'b1, c_idle, 1'b0, c_ctrl, 32'd0, 1'b1);
    @(negedge HCLK);
    check("idle_hrdata", HRDATA, 32'd0);
    step(1'b0, c_nonseq, 1'b0, c_ctrl, 32'd0, 1'b1);
    @(negedge HCLK);
    check("unsel_hrdata", HRDATA, 32'd0);

    // Flag clear with counter stopped.
    wr_reg(c_ctrl, 32'h0000_0002);
    wr_reg(c_status, 32'd1);
    rd_check(c_status, 32'd0, "clr_flag");
    check("clr_irq", {31'd0, IRQ}, 32'd0);

    // LOAD=0, PRESC=0: every cycle is an expiry, so the clear collides with a set.
    wr_reg(c_load, 32'd0);
    wr_reg(c_ctrl, 32'h0000_0003);
    idle();
    idle();
    wr_reg(c_status, 32'd1);
    rd_check(c_status, 32'd1, "set_beats_clear");
    check("set_beats_clear_irq", {31'd0, IRQ}, 32'd1);
    wr_reg(c_ctrl, 32'h0000_0002);
    wr_reg(c_status, 32'd1);
    rd_check(c_status, 32'd0, "clr_nontick");
    check("clr_nontick_irq", {31'd0, IRQ}, 32'd0);

    // Stalled bus: write address phase with HREADY low must be ignored.
    idle();
    pend_wdata = 32'hDEAD_BEEF;
    step(1'b1, c_nonseq, 1'b1, c_load, 32'hDEAD_BEEF, 1'b0);
    idle();
    rd_check(c_load, 32'd0, "stall_no_write");

    // One-shot, PRESC=2: decrement every 3 cycles, then stop at zero.
    wr_reg(c_load, 32'd1);
    wr_reg(c_ctrl, 32'h0000_0207);
    for (int i = 0; i < 8; i++) rd_check(c_value, seq_oneshot[i], $sformatf("oneshot_value_%0d", i));
    check("oneshot_irq", {31'd0, IRQ}, 32'd1);
    rd_check(c_ctrl, 32'h0000_0206, "oneshot_en_cleared");
    idle();
    idle();
    rd_check(c_value, 32'd0, "oneshot_value_held");
    rd_check(c_status, 32'd1, "oneshot_flag");

    // Asynchronous reset while counting with FLAG=1.
    wr_reg(c_ctrl, 32'h0000_0003);
    repeat (4) idle();
    @(negedge HCLK);
    check("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, IRQ}, 32'd0);
    check("async_rst_hrdata", HRDATA, 32'd0);
    step(1'b1, c_nonseq, 1'b1, c_ctrl, 32'h0000_0007, 1'b1);
    pend_wdata = 32'h0000_0007;
    HRESETn = 1'b1;
    idle();
    rd_check(c_ctrl,  32'd0,      "post_rst_ctrl");
    rd_check(c_load,  RESET_LOAD, "post_rst_load");
    rd_check(c_value, RESET_LOAD, "post_rst_value");
    rd_check(c_status, 32'd0,     "post_rst_status");

    idle();
    cmp_on = 1'b0;
    @(posedge HCLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_timer.md
AHB_TIMER -- requirements
Module: ahb_timer

Interface
REQ-001 Parameter PRESC_W, 8, width of prescaler field and prescale counter (1..16).
REQ-002 Parameter RESET_LOAD, 32'h0000_0000, reset value of LOAD register.
REQ-003 Reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-004 HCLK  input  1  system clock, all state on rising edge.
REQ-005 HRESETn  input  1  asynchronous active-low reset.
REQ-006 HSEL  input  1  slave select from address decoder.
REQ-007 HADDR  input  32  address; only HADDR[3:2] decoded, all other bits ignored.
REQ-008 HTRANS  input  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) marks valid transfer.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HSIZE  input  3  ignored; all accesses treated as 32-bit.
REQ-011 HWDATA  input  32  write data, sampled in data phase.
REQ-012 HREADY  input  1  bus-wide ready (from interconnect); address phase accepted only when 1.
REQ-013 HREADYOUT  output  1  slave ready; constant 1 (zero wait state).
REQ-014 HRESP  output  1  constant 0 (OKAY).
REQ-015 HRDATA  output  32  read data, valid in data phase.
REQ-016 IRQ  output  1  level interrupt = STATUS.FLAG & CTRL.IRQ_EN.

Function
REQ-017 Register map (offset HADDR[3:2]): 0x0 CTRL, 0x4 LOAD, 0x8 VALUE (read-only), 0xC STATUS.
REQ-018 CTRL bits: [0] EN, [1] IRQ_EN, [2] ONESHOT, [8+PRESC_W-1:8] PRESC; other bits read 0, writes ignored.
REQ-019 STATUS bit [0] FLAG; write 1 clears, write 0 no effect; other bits read 0.
REQ-020 Address phase accepted when HSEL & HREADY & HTRANS[1]; capture HADDR[3:2], HWRITE, valid flag into data-phase registers.
REQ-021 Data-phase registers cleared (valid=0) whenever HREADY=1 and no transfer accepted.
REQ-022 Write commits on the HCLK edge ending its data phase, using HWDATA of that cycle.
REQ-023 Read: HRDATA combinationally selects the captured register from current register contents; HRDATA=0 when no valid read data phase.
REQ-024 Back-to-back write then read of same register: read returns newly written value.
REQ-025 Write to VALUE ignored; write to LOAD also sets VALUE=HWDATA and clears prescale counter.
REQ-026 Prescale counter PCNT: while EN=1, increments each cycle; on PCNT==PRESC generates tick and returns to 0; while EN=0, held at 0.
REQ-027 On tick with VALUE!=0: VALUE decrements by 1.
REQ-028 On tick with VALUE==0: FLAG set; if ONESHOT=0 VALUE<=LOAD; if ONESHOT=1 EN cleared, VALUE stays 0.
REQ-029 Period (ONESHOT=0) = (LOAD+1)*(PRESC+1) HCLK cycles; LOAD=0 sets FLAG every tick.
REQ-030 Simultaneous FLAG set and STATUS write-1-clear: set wins, FLAG=1.
REQ-031 Simultaneous tick and CTRL write: CTRL write wins for all CTRL bits; VALUE/FLAG update from tick still occurs.
REQ-032 Simultaneous tick and LOAD write: LOAD write wins for VALUE and PCNT; no FLAG set that cycle.
REQ-033 VALUE arithmetic modulo 2^32; no underflow below 0 (reload/stop per REQ-028).

Reset
REQ-034 On HRESETn=0: CTRL=0, LOAD=RESET_LOAD, VALUE=RESET_LOAD, FLAG=0, PCNT=0, data-phase valid=0.
REQ-035 During and after reset: HREADYOUT=1, HRESP=0, HRDATA=0, IRQ=0.
REQ-036 Reset asserted mid-transfer or mid-count aborts immediately; no write commits on reset release edge.

Verification
REQ-037 Write LOAD=3, CTRL=0x1 (PRESC=0) -> VALUE reads 3,2,1,0 on consecutive cycles, FLAG=1 one cycle after VALUE=0, VALUE reloads to 3; period 4 cycles.
REQ-038 LOAD=1, CTRL=0x0000_0207 (PRESC=2, ONESHOT, IRQ_EN, EN) -> VALUE decrements every 3 cycles, FLAG and IRQ rise, EN reads 0, VALUE holds 0.
REQ-039 FLAG=1, write STATUS=0x1 on cycle where tick sets FLAG -> FLAG stays 1; repeat on non-tick cycle -> FLAG=0, IRQ=0.
REQ-040 Write CTRL=0x3 then immediately read CTRL -> HRDATA=0x0000_0003; read with HTRANS=IDLE or HSEL=0 -> no register change, HRDATA=0.
REQ-041 HREADY=0 (other slave stalling) with HSEL=1, HTRANS=NONSEQ, HWRITE=1 to LOAD -> transfer not accepted, LOAD unchanged.
REQ-042 Assert HRESETn=0 while counting with FLAG=1 -> all registers at reset values, IRQ=0 asynchronously.
